uart_frame_reader: RTL and testbench
====================================

UART_FRAME_READER -- requirements
Module: uart_frame_reader

Interface
REQ-001 SHALL have parameter UART_BUS_SIZE, default 8, width of one UART FIFO word.
REQ-002 SHALL have parameter OUT_BUS_SIZE, default 32, assembled word width; integer multiple of UART_BUS_SIZE; MAX_BYTES = OUT_BUS_SIZE/UART_BUS_SIZE.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0, maximum consecutive empty-FIFO cycles per byte; 0 disables timeout.
REQ-004 SHALL have derived localparam LEN_W = $clog2(MAX_BYTES)+1.
REQ-005 i_clk  input  1  clock; all logic on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_start_rd  input  1  request a frame read; sampled only in IDLE.
REQ-008 i_rd_len  input  LEN_W  number of UART words in frame; latched with start.
REQ-009 i_big_endian  input  1  byte order; latched with start.
REQ-010 i_abort  input  1  cancel frame in progress.
REQ-011 i_uart_empty  input  1  UART RX FIFO empty flag.
REQ-012 i_uart_data_rd  input  UART_BUS_SIZE  UART RX FIFO head word.
REQ-013 o_uart_rd  output  1  FIFO pop strobe, registered.
REQ-014 o_rd_end  output  1  one-cycle frame-complete pulse, registered.
REQ-015 o_rd_timeout  output  1  one-cycle timeout pulse, registered.
REQ-016 o_busy  output  1  high while in WAIT or POP.
REQ-017 o_rd_data  output  OUT_BUS_SIZE  assembled frame, registered.

Function
REQ-018 SHALL implement states IDLE, WAIT, POP, DONE.
REQ-019 IDLE: on i_start_rd, SHALL latch len (i_rd_len; 0 or >MAX_BYTES replaced by MAX_BYTES) and endianness, clear o_rd_data to 0, clear byte index and timeout counter, go to WAIT.
REQ-020 WAIT with i_uart_empty=0: SHALL write i_uart_data_rd into the slot of byte index k, clear timeout counter, go to POP.
REQ-021 Slot for byte k SHALL be bits [k*UART_BUS_SIZE +: UART_BUS_SIZE] little-endian, [(len-1-k)*UART_BUS_SIZE +: UART_BUS_SIZE] big-endian; frame right-aligned, unused upper bits stay 0.
REQ-022 POP: o_uart_rd SHALL be 1 for exactly this one cycle; k increments; next state DONE if k+1==len, else WAIT.
REQ-023 DONE: o_rd_end SHALL be 1 for exactly one cycle; next state IDLE.
REQ-024 o_rd_data SHALL hold its value from DONE until the next accepted start or reset.
REQ-025 Latency: with FIFO never empty, start sampled at edge 0 -> POP strobes at cycles 2,4,..,2*len, o_rd_end at cycle 2*len+1.
REQ-026 WAIT with i_uart_empty=1 and TIMEOUT_CYCLES>0: counter increments; at count==TIMEOUT_CYCLES-1 SHALL pulse o_rd_timeout one cycle, go to IDLE, no o_rd_end, o_rd_data keeps partial frame.
REQ-027 i_abort in WAIT or DONE SHALL go to IDLE next cycle with no o_rd_end and no pop; in POP the pop strobe already asserted completes, then IDLE.
REQ-028 i_abort has priority over data capture and timeout in the same cycle.
REQ-029 i_start_rd outside IDLE SHALL be ignored; i_abort in IDLE SHALL have no effect.
REQ-030 o_uart_rd SHALL never assert while i_uart_empty was 1 at the capture cycle.

Reset
REQ-031 i_reset SHALL override all inputs, including mid-frame: state IDLE, o_rd_data 0, o_uart_rd 0, o_rd_end 0, o_rd_timeout 0, o_busy 0, index and counter 0.

Verification
REQ-032 FIFO holds 11,22,33,44; start len=4, LE -> four pops at cycles 2,4,6,8; o_rd_end at 9; o_rd_data=0x44332211.
REQ-033 Same bytes, big-endian, len=4 -> o_rd_data=0x11223344; len=2 BE with AA,BB -> 0x0000AABB.
REQ-034 len=0 with 4 bytes available -> treated as 4, o_rd_end after 4 pops.
REQ-035 TIMEOUT_CYCLES=5, one byte 5A then FIFO empty, len=2 -> one pop, o_rd_timeout pulse after 5 empty cycles, no o_rd_end, o_rd_data=0x0000005A.
REQ-036 i_abort asserted in WAIT after byte 1, then new start len=1 with byte 7E -> no o_rd_end for first frame; second yields 0x0000007E.
REQ-037 i_reset asserted in POP -> next cycle all outputs 0, state IDLE; i_start_rd during busy ignored (no extra pops).

Source files
------------

// File: rtl/uart_frame_reader.sv
// Pops up to MAX_BYTES words from a UART RX FIFO and packs them into one output
// word in the requested byte order, with optional per-byte empty-FIFO timeout.
//   state | meaning
//   IDLE  | waiting for i_start_rd
//   WAIT  | waiting for a FIFO word (captures it when not empty)
//   POP   | pop strobe to the FIFO, advance byte index
//   DONE  | frame-complete pulse
module uart_frame_reader #(
    parameter int UART_BUS_SIZE  = 8,
    parameter int OUT_BUS_SIZE   = 32,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int MAX_BYTES     = OUT_BUS_SIZE / UART_BUS_SIZE,
    localparam int LEN_W         = $clog2(MAX_BYTES) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start_rd,
    input  logic [LEN_W-1:0]         i_rd_len,
    input  logic                     i_big_endian,
    input  logic                     i_abort,
    input  logic                     i_uart_empty,
    input  logic [UART_BUS_SIZE-1:0] i_uart_data_rd,
    output logic                     o_uart_rd,
    output logic                     o_rd_end,
    output logic                     o_rd_timeout,
    output logic                     o_busy,
    output logic [OUT_BUS_SIZE-1:0]  o_rd_data
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, POP, DONE} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  idx;
    logic [TO_W-1:0]   cnt;
    logic              big;
    logic [LEN_W-1:0]  len_in;
    logic [LEN_W-1:0]  slot;

    always_comb begin
        len_in = i_rd_len;
        if (i_rd_len == '0 || i_rd_len > LEN_MAX)
            len_in = LEN_MAX;
        // Big-endian puts byte 0 in the highest slot of the right-aligned frame.
        slot = big ? (len - idx - LEN_W'(1)) : idx;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            len          <= '0;
            idx          <= '0;
            cnt          <= '0;
            big          <= 1'b0;
            o_uart_rd    <= 1'b0;
            o_rd_end     <= 1'b0;
            o_rd_timeout <= 1'b0;
            o_busy       <= 1'b0;
            o_rd_data    <= '0;
        end else begin
            o_uart_rd    <= 1'b0;
            o_rd_end     <= 1'b0;
            o_rd_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start_rd) begin
                        len       <= len_in;
                        big       <= i_big_endian;
                        o_rd_data <= '0;
                        idx       <= '0;
                        cnt       <= '0;
                        o_busy    <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_abort) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else if (!i_uart_empty) begin
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (slot == LEN_W'(i))
                                o_rd_data[i*UART_BUS_SIZE +: UART_BUS_SIZE] <= i_uart_data_rd;
                        end
                        cnt       <= '0;
                        o_uart_rd <= 1'b1;
                        state     <= POP;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        if (cnt == TO_LAST) begin
                            o_rd_timeout <= 1'b1;
                            o_busy       <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt + TO_W'(1);
                        end
                    end
                end
                POP: begin
                    idx <= idx + LEN_W'(1);
                    if (i_abort) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else if (idx + LEN_W'(1) == len) begin
                        o_rd_end <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_reader.sv
// Self-checking bench for uart_frame_reader: a queue-backed FIFO model plus a
// reference packer compare timing and assembled words against the DUT.
module tb_uart_frame_reader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_rd = 1'b0;
    logic [2:0]  rd_len = '0;
    logic        big = 1'b0;
    logic        abort = 1'b0;
    logic        uart_empty = 1'b1;
    logic [7:0]  uart_data = 8'hEE;
    logic        uart_rd, rd_end, rd_timeout, busy;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int underflow = 0;
    logic [7:0] fifo[$];
    int pops[$];
    int ends[$];
    int tos[$];

    uart_frame_reader #(.UART_BUS_SIZE(8), .OUT_BUS_SIZE(32), .TIMEOUT_CYCLES(5)) dut (
        .i_clk(clk), .i_reset(rst), .i_start_rd(start_rd), .i_rd_len(rd_len),
        .i_big_endian(big), .i_abort(abort), .i_uart_empty(uart_empty),
        .i_uart_data_rd(uart_data), .o_uart_rd(uart_rd), .o_rd_end(rd_end),
        .o_rd_timeout(rd_timeout), .o_busy(busy), .o_rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // FIFO model and event recorder; cycle numbers are 1-based from the start edge.
    always @(negedge clk) begin
        if (uart_rd) begin
            pops.push_back(cyc - t0 + 1);
            if (fifo.size() == 0) underflow++;
            else void'(fifo.pop_front());
        end
        if (rd_end) ends.push_back(cyc - t0 + 1);
        if (rd_timeout) tos.push_back(cyc - t0 + 1);
        uart_empty = (fifo.size() == 0);
        uart_data  = (fifo.size() == 0) ? 8'hEE : fifo[0];
    end

    function automatic int eff_len(input int l);
        return (l == 0 || l > 4) ? 4 : l;
    endfunction

    function automatic logic [31:0] model_word(input byte_q_t b, input int l, input bit be);
        logic [31:0] w = '0;
        for (int k = 0; k < b.size() && k < l; k++)
            w = w | (32'(b[k]) << ((be ? (l - 1 - k) : k) * 8));
        return w;
    endfunction

    function automatic bit pops_ok(input int l);
        if (pops.size() != l) return 1'b0;
        foreach (pops[i]) if (pops[i] != 2 * (i + 1)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_bytes(input byte_q_t b);
        foreach (b[i]) fifo.push_back(b[i]);
    endtask

    task automatic start_frame(input int l, input bit be);
        @(negedge clk);
        rd_len = 3'(l);
        big = be;
        start_rd = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start_rd = 1'b0;
        pops.delete(); ends.delete(); tos.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (uart_rd !== 1'b0) begin n_fail++; $display("FAIL reset_uart_rd: got %b want 0", uart_rd); end
        if (rd_end !== 1'b0) begin n_fail++; $display("FAIL reset_rd_end: got %b want 0", rd_end); end
        if (rd_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", rd_timeout); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rd_data); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame(input string name, input byte_q_t b, input int l, input bit be);
        int le = eff_len(l);
        logic [31:0] exp = model_word(b, le, be);
        push_bytes(b);
        start_frame(l, be);
        repeat (2 * le + 4) @(negedge clk);
        n_checks += 4;
        if (!pops_ok(le)) begin n_fail++; $display("FAIL %s_pops: got %0d pops (first %0d) want %0d at cycles 2,4,..", name, pops.size(), (pops.size() > 0) ? pops[0] : -1, le); end
        if (ends.size() != 1 || ends[0] != 2 * le + 1) begin n_fail++; $display("FAIL %s_end: got %0d pulses (first %0d) want one at %0d", name, ends.size(), (ends.size() > 0) ? ends[0] : -1, 2 * le + 1); end
        if (rd_data !== exp) begin n_fail++; $display("FAIL %s_data: got %h want %h", name, rd_data, exp); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b want 0", name, busy); end
    endtask

    task automatic test_basic();
        test_frame("le4", '{8'h11, 8'h22, 8'h33, 8'h44}, 4, 1'b0);
        test_frame("be4", '{8'h11, 8'h22, 8'h33, 8'h44}, 4, 1'b1);
        test_frame("be2", '{8'hAA, 8'hBB}, 2, 1'b1);
        test_frame("len0", '{8'h01, 8'h02, 8'h03, 8'h04}, 0, 1'b0);
        test_frame("len7", '{8'hC1, 8'hC2, 8'hC3, 8'hC4}, 7, 1'b1);
    endtask

    task automatic test_timeout();
        push_bytes('{8'h5A});
        start_frame(2, 1'b0);
        repeat (14) @(negedge clk);
        n_checks += 5;
        if (pops.size() != 1 || pops[0] != 2) begin n_fail++; $display("FAIL to_pops: got %0d pops want 1 at cycle 2", pops.size()); end
        if (tos.size() != 1 || tos[0] != 2 + 5 + 1) begin n_fail++; $display("FAIL to_pulse: got %0d pulses (first %0d) want one at 8", tos.size(), (tos.size() > 0) ? tos[0] : -1); end
        if (ends.size() != 0) begin n_fail++; $display("FAIL to_end: got %0d end pulses want 0", ends.size()); end
        if (rd_data !== 32'h0000005A) begin n_fail++; $display("FAIL to_data: got %h want 0000005a", rd_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        push_bytes('{8'h31});
        start_frame(3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (10) @(negedge clk);
        n_checks += 4;
        if (pops.size() != 1) begin n_fail++; $display("FAIL ab_pops: got %0d want 1", pops.size()); end
        if (ends.size() != 0) begin n_fail++; $display("FAIL ab_end: got %0d end pulses want 0", ends.size()); end
        if (tos.size() != 0) begin n_fail++; $display("FAIL ab_timeout: got %0d timeout pulses want 0", tos.size()); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b want 0", busy); end
        test_frame("ab_next", '{8'h7E}, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int l = int'($urandom_range(0, 7));
            int le = eff_len(l);
            bit be = 1'($urandom_range(0, 1));
            byte_q_t b;
            logic [31:0] exp;
            for (int k = 0; k < le; k++) b.push_back(8'($urandom));
            exp = model_word(b, le, be);
            push_bytes(b);
            start_frame(l, be);
            @(posedge clk); #1;
            @(posedge clk); #1;
            start_rd = 1'b1;
            @(posedge clk); #1;
            start_rd = 1'b0;
            repeat (2 * le + 4) @(negedge clk);
            n_checks += 4;
            if (!pops_ok(le)) begin n_fail++; $display("FAIL rnd%0d_pops: got %0d want %0d", it, pops.size(), le); end
            if (ends.size() != 1 || ends[0] != 2 * le + 1) begin n_fail++; $display("FAIL rnd%0d_end: got %0d pulses want one at %0d", it, ends.size(), 2 * le + 1); end
            if (rd_data !== exp) begin n_fail++; $display("FAIL rnd%0d_data: got %h want %h (len %0d be %0d)", it, rd_data, exp, l, be); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy: got %b want 0", it, busy); end
        end
    endtask

    task automatic test_reset_mid();
        push_bytes('{8'hD1, 8'hD2, 8'hD3, 8'hD4});
        start_frame(4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (uart_rd !== 1'b0) begin n_fail++; $display("FAIL rm_uart_rd: got %b want 0", uart_rd); end
        if (rd_end !== 1'b0) begin n_fail++; $display("FAIL rm_rd_end: got %b want 0", rd_end); end
        if (rd_timeout !== 1'b0) begin n_fail++; $display("FAIL rm_timeout: got %b want 0", rd_timeout); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL rm_data: got %h want 0", rd_data); end
        rst = 1'b0;
        fifo.delete();
        push_bytes('{8'hE1});
        repeat (8) @(negedge clk);
        n_checks += 2;
        if (pops.size() != 1 || pops[0] != 2) begin n_fail++; $display("FAIL rm_pops: got %0d want 1", pops.size()); end
        if (ends.size() != 0) begin n_fail++; $display("FAIL rm_end: got %0d want 0", ends.size()); end
        fifo.delete();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_abort();
        test_random();
        test_reset_mid();
        n_checks++;
        if (underflow != 0) begin n_fail++; $display("FAIL fifo_underflow: got %0d pops from empty FIFO want 0", underflow); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
